// File: rtl/noc_xbar_mover.sv
// Crossbar byte mover: takes one arbiter grant at a time, pops the source input FIFO,
// then pushes the held flit into the destination output FIFO once it has room.
module noc_xbar_mover (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  source,
    input  logic [1:0]  destination,
    input  logic        valid,
    input  logic [3:0]  fifo_empty,
    input  logic [7:0]  router_data_out_0,
    input  logic [7:0]  router_data_out_1,
    input  logic [7:0]  router_data_out_2,
    input  logic [7:0]  router_data_out_3,
    input  logic [3:0]  out_full,
    output logic [3:0]  fifo_rd_en,
    output logic [3:0]  out_wr_en,
    output logic [7:0]  out_data,
    output logic        busy,
    output logic [31:0] deliv_cnt,
    output logic [7:0]  drop_cnt
);

    typedef enum logic [1:0] {IDLE, POP, WAIT, PUSH} state_t;

    state_t     state_reg, state_next;
    logic [1:0] src_reg, src_next;
    logic [1:0] dst_reg, dst_next;
    logic [7:0] data_reg, data_next;
    logic [3:0] rd_next, wr_next;
    logic [7:0] out_data_next;
    logic       busy_next;
    logic [7:0] drop_next;
    logic [7:0] deliv_reg  [4];
    logic [7:0] deliv_next [4];
    logic [7:0] head_data  [4];
    logic       accept;
    logic       do_push;

    assign head_data[0] = router_data_out_0;
    assign head_data[1] = router_data_out_1;
    assign head_data[2] = router_data_out_2;
    assign head_data[3] = router_data_out_3;

    for (genvar gi = 0; gi < 4; gi++) begin : g_deliv
        assign deliv_cnt[8*gi +: 8] = deliv_reg[gi];
    end

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        return 4'(1) << idx;
    endfunction

    // Grants that arrive while a transfer is in flight are counted as drops, never queued.
    assign accept = (state_reg == IDLE) && valid && !fifo_empty[source] && !out_full[destination];

    always_comb begin
        state_next    = state_reg;
        src_next      = src_reg;
        dst_next      = dst_reg;
        data_next     = data_reg;
        rd_next       = 4'b0000;
        wr_next       = 4'b0000;
        out_data_next = out_data;
        busy_next     = busy;
        drop_next     = drop_cnt;
        deliv_next    = deliv_reg;
        do_push       = 1'b0;

        if (valid && !accept)
            drop_next = sat_inc(drop_cnt);

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    src_next   = source;
                    dst_next   = destination;
                    data_next  = head_data[source];
                    rd_next    = onehot(src_next);
                    state_next = POP;
                    busy_next  = 1'b1;
                end
            end
            POP, WAIT: begin
                if (!out_full[dst_reg])
                    do_push = 1'b1;
                else
                    state_next = WAIT;
            end
            PUSH: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
            default: state_next = IDLE;
        endcase

        if (do_push) begin
            state_next          = PUSH;
            wr_next             = onehot(dst_reg);
            out_data_next       = data_reg;
            deliv_next[dst_reg] = sat_inc(deliv_reg[dst_reg]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            src_reg    <= 2'd0;
            dst_reg    <= 2'd0;
            data_reg   <= 8'd0;
            fifo_rd_en <= 4'b0000;
            out_wr_en  <= 4'b0000;
            out_data   <= 8'd0;
            busy       <= 1'b0;
            drop_cnt   <= 8'd0;
            for (int i = 0; i < 4; i++)
                deliv_reg[i] <= 8'd0;
        end else begin
            state_reg  <= state_next;
            src_reg    <= src_next;
            dst_reg    <= dst_next;
            data_reg   <= data_next;
            fifo_rd_en <= rd_next;
            out_wr_en  <= wr_next;
            out_data   <= out_data_next;
            busy       <= busy_next;
            drop_cnt   <= drop_next;
            for (int i = 0; i < 4; i++)
                deliv_reg[i] <= deliv_next[i];
        end
    end

endmodule
